// File: rtl/wb_trace_uart_pkg.sv
//------------------------------------------------------------------------------
// trace_pkg : shared constants and types for the writeback trace UART.
// Define TRACE_INSTRUCTION_EN to carry the instruction word in every record.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package trace_pkg;

  localparam logic [7:0] TRACE_HDR_BASIC = 8'hA5;
  localparam logic [7:0] TRACE_HDR_INSTR = 8'hA6;

`ifdef TRACE_INSTRUCTION_EN
  localparam int         TRACE_REC_W       = 69;
  localparam int         TRACE_FRAME_BYTES = 10;
  localparam logic [7:0] TRACE_HDR         = TRACE_HDR_INSTR;
`else
  localparam int         TRACE_REC_W       = 37;
  localparam int         TRACE_FRAME_BYTES = 6;
  localparam logic [7:0] TRACE_HDR         = TRACE_HDR_BASIC;
`endif

  localparam int TRACE_FRAME_W = TRACE_FRAME_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Record is {addr, data[, instr]}; the frame prepends the header and pads addr to a byte.
  function automatic logic [TRACE_FRAME_W-1:0] build_frame(input logic [TRACE_REC_W-1:0] rec);
    return {TRACE_HDR, 3'b000, rec};
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_trace_uart_if.sv
//------------------------------------------------------------------------------
// wb_trace_uart_if : writeback-stage debug signals observed by the trace UART.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface wb_trace_uart_if;
  logic        wb_shouldWriteRegister;
  logic [4:0]  wb_registerWriteAddress;
  logic [31:0] wb_registerWriteData;
  logic [31:0] wb_instruction;

  modport master (
    output wb_shouldWriteRegister,
    output wb_registerWriteAddress,
    output wb_registerWriteData,
    output wb_instruction
  );

  modport slave (
    input wb_shouldWriteRegister,
    input wb_registerWriteAddress,
    input wb_registerWriteData,
    input wb_instruction
  );
endinterface

`default_nettype wire

// File: rtl/wb_trace_uart_fifo.sv
//------------------------------------------------------------------------------
// trace_fifo : synchronous FIFO with wrap-bit pointers; a push while full is
// accepted only when a pop happens on the same edge.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module trace_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] pushData,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] popData,
  output logic                  full,
  output logic                  empty
);

  localparam int c_AW = $clog2(DEPTH);

  logic [c_AW:0]      r_wrPtr;
  logic [c_AW:0]      r_rdPtr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_doPush;
  logic               w_doPop;

  assign empty    = (r_wrPtr == r_rdPtr);
  assign full     = (r_wrPtr[c_AW] != r_rdPtr[c_AW]) &&
                    (r_wrPtr[c_AW-1:0] == r_rdPtr[c_AW-1:0]);
  assign w_doPop  = pop & ~empty;
  assign w_doPush = push & (~full | w_doPop);
  assign popData  = r_mem[r_rdPtr[c_AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr[c_AW-1:0]] <= pushData;
  end

endmodule

`default_nettype wire

// File: rtl/wb_trace_uart.sv
//------------------------------------------------------------------------------
// wb_trace_uart : captures retired register writes and streams them as 8N1
// frames; drops and counts records when the FIFO is full. Option: TRACE_INSTRUCTION_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module wb_trace_uart
  import trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  wire logic        clock,
  input  wire logic        reset,
  wb_trace_uart_if.slave   wb,
  output logic             uartTx,
  output logic             traceBusy,
  output logic             traceOverflow,
  output logic [7:0]       droppedCount
);

  localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_BYTE_W = $clog2(TRACE_FRAME_BYTES);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BYTE_W-1:0] c_BYTE_LAST = c_BYTE_W'(TRACE_FRAME_BYTES - 1);

  localparam logic [1:0] c_IDLE  = IDLE;
  localparam logic [1:0] c_START = START;
  localparam logic [1:0] c_DATA  = DATA;
  localparam logic [1:0] c_STOP  = STOP;

  logic [1:0]               r_state;
  logic [c_BAUD_W-1:0]      r_baud;
  logic [2:0]               r_bitCnt;
  logic [c_BYTE_W-1:0]      r_byteLeft;
  logic [TRACE_FRAME_W-1:0] r_frame;
  logic                     r_tx;
  logic                     r_busy;
  logic                     r_overflow;
  logic [7:0]               r_dropped;

  logic                     w_capture;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_baudEnd;
  logic                     w_txBit;
  logic [7:0]               w_curByte;
  logic [TRACE_REC_W-1:0]   w_recIn;
  logic [TRACE_REC_W-1:0]   w_popData;

`ifdef TRACE_INSTRUCTION_EN
  assign w_recIn = {wb.wb_registerWriteAddress, wb.wb_registerWriteData, wb.wb_instruction};
`else
  logic w_unusedInstr;
  assign w_unusedInstr = ^wb.wb_instruction;
  assign w_recIn       = {wb.wb_registerWriteAddress, wb.wb_registerWriteData};
`endif

  assign w_capture = wb.wb_shouldWriteRegister & (wb.wb_registerWriteAddress != 5'd0);
  assign w_pop     = (r_state == c_IDLE) & ~w_empty;
  assign w_baudEnd = (r_baud == c_BAUD_LAST);
  assign w_curByte = r_frame[TRACE_FRAME_W-1 -: 8];

  trace_fifo #(
    .WIDTH (TRACE_REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (w_capture),
    .pushData (w_recIn),
    .pop      (w_pop),
    .popData  (w_popData),
    .full     (w_full),
    .empty    (w_empty)
  );

  // A same-edge pop frees a slot, so only a full FIFO without a pop drops.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_dropped  <= '0;
      r_overflow <= 1'b0;
    end else if (w_capture && w_full && !w_pop) begin
      r_overflow <= 1'b1;
      if (r_dropped != 8'hFF) r_dropped <= r_dropped + 1'b1;
    end
  end

  always_comb begin
    w_txBit = 1'b1;
    case (r_state)
      c_START: w_txBit = 1'b0;
      c_DATA:  w_txBit = w_curByte[r_bitCnt];
      default: w_txBit = 1'b1;
    endcase
  end

  // The line is registered one cycle behind the state, giving capture-to-start latency of 2.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_baud     <= '0;
      r_bitCnt   <= '0;
      r_byteLeft <= '0;
      r_frame    <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_tx   <= w_txBit;
      r_busy <= (r_state != c_IDLE) | ~w_empty;
      case (r_state)
        c_IDLE: begin
          if (!w_empty) begin
            r_frame    <= build_frame(w_popData);
            r_byteLeft <= c_BYTE_LAST;
            r_baud     <= '0;
            r_state    <= c_START;
          end
        end
        c_START: begin
          if (w_baudEnd) begin
            r_baud   <= '0;
            r_bitCnt <= '0;
            r_state  <= c_DATA;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        c_DATA: begin
          if (w_baudEnd) begin
            r_baud <= '0;
            if (r_bitCnt == 3'd7) r_state  <= c_STOP;
            else                  r_bitCnt <= r_bitCnt + 1'b1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        c_STOP: begin
          if (w_baudEnd) begin
            r_baud <= '0;
            if (r_byteLeft != '0) begin
              r_byteLeft <= r_byteLeft - 1'b1;
              r_frame    <= r_frame << 8;
              r_state    <= c_START;
            end else begin
              r_state <= c_IDLE;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign uartTx        = r_tx;
  assign traceBusy     = r_busy;
  assign traceOverflow = r_overflow;
  assign droppedCount  = r_dropped;

endmodule

`default_nettype wire

// File: tb/tb_wb_trace_uart.sv
//------------------------------------------------------------------------------
// tb_wb_trace_uart : scoreboard bench; a cycle-level record model predicts every
// UART byte and its start cycle, a line decoder pops and compares them.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_wb_trace_uart;

  localparam int C = 4;
  localparam int D = 4;
`ifdef TRACE_INSTRUCTION_EN
  localparam int NB = 10;
`else
  localparam int NB = 6;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       uartTx;
  logic       traceBusy;
  logic       traceOverflow;
  logic [7:0] droppedCount;

  always #5 clock = ~clock;

  wb_trace_uart_if bus ();

  wb_trace_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clock         (clock),
    .reset         (reset),
    .wb            (bus),
    .uartTx        (uartTx),
    .traceBusy     (traceBusy),
    .traceOverflow (traceOverflow),
    .droppedCount  (droppedCount)
  );

  typedef struct { logic [4:0] a; logic [31:0] d; logic [31:0] i; } rec_t;
  typedef struct { logic [7:0] b; longint t; } exp_t;

  rec_t   mq[$];
  exp_t   expQ[$];
  longint cyc     = 0;
  longint mFreeAt = 0;
  int     mDrop   = 0;
  logic   mOvf    = 1'b0;
  int     epoch   = 0;
  int     errors  = 0;
  int     checks  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: records wait in a D-deep queue; the serializer takes one
  // whenever it is free, and is busy for NB*10*C cycles plus one idle cycle.
  always @(posedge clock) begin : p_model
    rec_t   r;
    exp_t   e;
    logic [7:0] bq[$];
    cyc++;
    if (reset) begin
      mq.delete();
      expQ.delete();
      mFreeAt = 0;
      mDrop   = 0;
      mOvf    = 1'b0;
      epoch++;
    end else begin
      if (mq.size() > 0 && cyc >= mFreeAt) begin
        r  = mq.pop_front();
`ifdef TRACE_INSTRUCTION_EN
        bq = '{8'hA6, {3'b000, r.a}, r.d[31:24], r.d[23:16], r.d[15:8], r.d[7:0],
               r.i[31:24], r.i[23:16], r.i[15:8], r.i[7:0]};
`else
        bq = '{8'hA5, {3'b000, r.a}, r.d[31:24], r.d[23:16], r.d[15:8], r.d[7:0]};
`endif
        for (int k = 0; k < NB; k++) begin
          e.b = bq[k];
          e.t = cyc + 1 + longint'(10 * C * k);
          expQ.push_back(e);
        end
        mFreeAt = cyc + 10 * C * NB + 1;
      end
      if (bus.wb_shouldWriteRegister && bus.wb_registerWriteAddress != 5'd0) begin
        r.a = bus.wb_registerWriteAddress;
        r.d = bus.wb_registerWriteData;
        r.i = bus.wb_instruction;
        if (mq.size() < D) mq.push_back(r);
        else begin
          mDrop = (mDrop < 255) ? mDrop + 1 : 255;
          mOvf  = 1'b1;
        end
      end
    end
  end

  // Line decoder: samples mid-bit and compares with the scoreboard head.
  initial begin : p_mon
    longint     s;
    int         ep;
    logic [7:0] b;
    logic       startOk;
    logic       stopOk;
    exp_t       e;
    forever begin
      @(negedge clock);
      if (uartTx === 1'b0) begin
        s  = cyc;
        ep = epoch;
        repeat (C / 2) @(negedge clock);
        startOk = (uartTx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (C) @(negedge clock);
          b[i] = uartTx;
        end
        repeat (C) @(negedge clock);
        stopOk = (uartTx === 1'b1);
        if (ep == epoch) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected byte: got %0h at cycle %0d, expected no traffic", b, s);
          end else begin
            e = expQ.pop_front();
            check("byte value", b, e.b);
            check("byte start cycle", s, e.t);
            check("start bit level", startOk, 1'b1);
            check("stop bit level", stopOk, 1'b1);
          end
        end
      end
    end
  end

  task automatic setWr(input logic we, input logic [4:0] a, input logic [31:0] d, input logic [31:0] i);
    bus.wb_shouldWriteRegister  = we;
    bus.wb_registerWriteAddress = a;
    bus.wb_registerWriteData    = d;
    bus.wb_instruction          = i;
  endtask

  task automatic waitCyc(input longint t);
    while (cyc < t) @(negedge clock);
  endtask

  task automatic drain();
    int n = 0;
    while ((expQ.size() != 0 || mq.size() != 0 || cyc < mFreeAt + 12 * C) && n < 20000) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      errors++;
      $display("FAIL drain timeout: got %0d pending bytes, expected 0", expQ.size());
    end
    check("idle line after drain", uartTx, 1'b1);
    check("busy low after drain", traceBusy, 1'b0);
  endtask

  initial begin : p_stim
    longint n0;
    logic   anyLow;
    logic   anyBusy;
    #500_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : p_main
    longint n0;
    logic   anyLow;
    logic   anyBusy;
    setWr(1'b0, 5'd0, 32'd0, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset uartTx", uartTx, 1'b1);
    check("reset traceBusy", traceBusy, 1'b0);
    check("reset traceOverflow", traceOverflow, 1'b0);
    check("reset droppedCount", droppedCount, 8'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single write: latency, then busy falling right after the last stop bit.
    n0 = cyc + 1;
    setWr(1'b1, 5'd5, 32'hDEADBEEF, 32'h0);
    @(negedge clock);
    setWr(1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clock);
    check("line high one cycle after capture", uartTx, 1'b1);
    @(negedge clock);
    check("start bit two cycles after capture", uartTx, 1'b0);
    check("busy during frame", traceBusy, 1'b1);
    waitCyc(n0 + 1 + 10 * C * NB);
    check("busy through last stop bit", traceBusy, 1'b1);
    @(negedge clock);
    check("busy low after last stop bit", traceBusy, 1'b0);
    drain();

    // Writes to $0 are ignored.
    setWr(1'b1, 5'd0, 32'h12345678, 32'h0);
    @(negedge clock);
    setWr(1'b0, 5'd0, 32'd0, 32'd0);
    anyLow  = 1'b0;
    anyBusy = 1'b0;
    repeat (30) begin
      @(negedge clock);
      anyLow  |= ~uartTx;
      anyBusy |= traceBusy;
    end
    check("zero reg: line activity", anyLow, 1'b0);
    check("zero reg: busy", anyBusy, 1'b0);

    // Burst of 8: one in flight, four queued, three dropped.
    for (int k = 1; k <= 8; k++) begin
      setWr(1'b1, 5'(k), $urandom, $urandom);
      @(negedge clock);
    end
    setWr(1'b0, 5'd0, 32'd0, 32'd0);
    check("burst droppedCount", droppedCount, 8'd3);
    check("burst traceOverflow", traceOverflow, 1'b1);

    // Full FIFO, write landing on the pop edge is accepted.
    waitCyc(mFreeAt - 1);
    setWr(1'b1, 5'd9, 32'hCAFEF00D, 32'h0);
    @(negedge clock);
    setWr(1'b0, 5'd0, 32'd0, 32'd0);
    check("pop-edge push droppedCount", droppedCount, 8'd3);
    drain();
    check("sticky overflow", traceOverflow, 1'b1);

    // Reset while byte 3 is in its data bits, with records still queued.
    n0 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      setWr(1'b1, 5'(3 + k), $urandom, $urandom);
      @(negedge clock);
    end
    setWr(1'b0, 5'd0, 32'd0, 32'd0);
    waitCyc(n0 + 1 + 20 * C + C + 5);
    reset = 1'b1;
    @(negedge clock);
    check("mid-frame reset uartTx", uartTx, 1'b1);
    check("mid-frame reset traceBusy", traceBusy, 1'b0);
    check("mid-frame reset droppedCount", droppedCount, 8'd0);
    check("mid-frame reset traceOverflow", traceOverflow, 1'b0);
    reset = 1'b0;
    anyLow = 1'b0;
    repeat (10 * C * NB) begin
      @(negedge clock);
      anyLow |= ~uartTx;
    end
    check("no stale frame after reset", anyLow, 1'b0);
    setWr(1'b1, 5'd12, 32'h0BADC0DE, 32'h0);
    @(negedge clock);
    setWr(1'b0, 5'd0, 32'd0, 32'd0);
    drain();

    // Random traffic, including $0 writes and overflow bursts.
    for (int k = 0; k < 300; k++) begin
      setWr(($urandom % 6) == 0, 5'($urandom % 32), $urandom, $urandom);
      @(negedge clock);
    end
    setWr(1'b0, 5'd0, 32'd0, 32'd0);
    drain();
    check("random droppedCount", droppedCount, 8'(mDrop));
    check("random traceOverflow", traceOverflow, mOvf);

`ifdef TRACE_INSTRUCTION_EN
    setWr(1'b1, 5'd31, 32'h0000_0001, 32'h03E0_0008);
    @(negedge clock);
    setWr(1'b0, 5'd0, 32'd0, 32'd0);
    drain();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
